qpsk_tx_framer: RTL and testbench

//  Converts a byte stream into framed, oversampled QPSK I/Q samples for the AD9363 TX path.

---
 rtl/qpsk_tx_framer.sv | 215 +++++++++++++++++++++
 tb/tb_qpsk_tx_framer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_tx_framer.sv
// qpsk_tx_framer: byte stream -> framed, oversampled QPSK {I,Q} samples.
// Frame = alternating preamble, payload (MSB-first dibits), zero guard gap.
// Optional build macro QPSK_SCRAMBLER_EN adds an additive x^7+x^4+1 payload scrambler.
module qpsk_tx_framer #(
    parameter int SPS           = 4,
    parameter int AMP           = 1024,
    parameter int PREAMBLE_SYMS = 32,
    parameter int GAP_SAMPLES   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        out_valid,
    output logic [23:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        underrun
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;

    localparam logic [11:0] POS       = 12'(AMP);
    localparam logic [11:0] NEG       = 12'(-AMP);
    localparam logic [3:0]  SAMP_LAST = 4'(SPS - 1);
    localparam logic [7:0]  PRE_LAST  = 8'(PREAMBLE_SYMS - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_SAMPLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  samp_cnt;
    logic [7:0]  sym_cnt;
    logic [7:0]  gap_cnt;
    logic [7:0]  shreg;
    logic        cur_last;
    logic [7:0]  hold_data;
    logic        hold_last;
    logic        hold_full;
    logic        last_seen;
    logic        starve;
    logic        init_done;

    logic        adv, accept, samp_end, sym_end;
    logic        load_byte, start_starve, stop_starve;
    logic [1:0]  dibit, sym_bits;

    assign adv      = out_valid && out_ready;
    assign accept   = s_valid && s_ready;
    assign samp_end = (samp_cnt == SAMP_LAST);
    assign sym_end  = adv && samp_end;

`ifdef QPSK_SCRAMBLER_EN
    logic [6:0] lfsr;
    logic       scr_o1, scr_o2;
    // Two scrambler bits per symbol: o1 for the MSB, o2 from the once-stepped state.
    assign scr_o1   = lfsr[6] ^ lfsr[3];
    assign scr_o2   = lfsr[5] ^ lfsr[2];
    assign sym_bits = dibit ^ {scr_o1, scr_o2};

    // Reseed at frame start, advance two bits per emitted payload symbol.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 7'h7F;
        end else if (state_q == IDLE && accept) begin
            lfsr <= 7'h7F;
        end else if (state_q == PAYLOAD && sym_end && !starve) begin
            lfsr <= {lfsr[4:0], scr_o1, scr_o2};
        end
    end
`else
    assign sym_bits = dibit;
`endif

    // Pick the current dibit of the shift register, MSB pair first.
    always_comb begin
        dibit = 2'b00;
        case (sym_cnt[1:0])
            2'd0: dibit = shreg[7:6];
            2'd1: dibit = shreg[5:4];
            2'd2: dibit = shreg[3:2];
            2'd3: dibit = shreg[1:0];
            default: dibit = 2'b00;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and payload sequencing strobes; nothing moves without a sample step.
    always_comb begin
        state_d      = state_q;
        load_byte    = 1'b0;
        start_starve = 1'b0;
        stop_starve  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = PREAMBLE;
            end
            PREAMBLE: begin
                if (sym_end && sym_cnt == PRE_LAST) state_d = PAYLOAD;
            end
            PAYLOAD: begin
                if (sym_end) begin
                    if (starve) begin
                        if (hold_full) begin
                            load_byte   = 1'b1;
                            stop_starve = 1'b1;
                        end
                    end else if (sym_cnt == 8'd3) begin
                        if (cur_last)       state_d = (GAP_SAMPLES == 0) ? IDLE : GAP;
                        else if (hold_full) load_byte = 1'b1;
                        else                start_starve = 1'b1;
                    end
                end
            end
            GAP: begin
                if (adv && gap_cnt == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, byte registers and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_cnt  <= '0;
            sym_cnt   <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
            cur_last  <= 1'b0;
            hold_data <= '0;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
            last_seen <= 1'b0;
            starve    <= 1'b0;
            underrun  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (state_q == IDLE) begin
                samp_cnt  <= '0;
                sym_cnt   <= '0;
                gap_cnt   <= '0;
                starve    <= 1'b0;
                hold_full <= 1'b0;
                last_seen <= accept && s_last;
                if (accept) begin
                    shreg    <= s_data;
                    cur_last <= s_last;
                    underrun <= 1'b0;
                end
            end else begin
                if (adv) samp_cnt <= samp_end ? 4'd0 : samp_cnt + 4'd1;
                if (sym_end) begin
                    if (state_q == PREAMBLE)
                        sym_cnt <= (sym_cnt == PRE_LAST) ? 8'd0 : sym_cnt + 8'd1;
                    else if (state_q == PAYLOAD)
                        sym_cnt <= (starve || sym_cnt == 8'd3) ? 8'd0 : sym_cnt + 8'd1;
                end
                if (adv && state_q == GAP) gap_cnt <= gap_cnt + 8'd1;

                // Draw from the holding register happens before any refill.
                if (load_byte) begin
                    shreg    <= hold_data;
                    cur_last <= hold_last;
                end
                hold_full <= (hold_full && !load_byte) || accept;
                if (accept) begin
                    hold_data <= s_data;
                    hold_last <= s_last;
                    if (s_last) last_seen <= 1'b1;
                end

                if (start_starve) begin
                    starve   <= 1'b1;
                    underrun <= 1'b1;
                end else if (stop_starve) begin
                    starve <= 1'b0;
                end
            end
        end
    end

    // Output mapping from registered state; stable across back-pressure stalls.
    always_comb begin
        out_valid = 1'b0;
        out_data  = 24'h0;
        s_ready   = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                s_ready = init_done;
            end
            PREAMBLE: begin
                out_valid = 1'b1;
                out_data  = sym_cnt[0] ? {NEG, NEG} : {POS, POS};
                s_ready   = !hold_full && !last_seen;
            end
            PAYLOAD: begin
                out_valid = 1'b1;
                if (!starve) out_data = {sym_bits[1] ? NEG : POS, sym_bits[0] ? NEG : POS};
                s_ready   = !hold_full && !last_seen;
            end
            GAP: begin
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qpsk_tx_framer.sv
module tb_qpsk_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_last, s_ready;
    logic [7:0]  s_data;
    logic        out_valid, out_ready, busy, underrun;
    logic [23:0] out_data;

    int tests = 0;
    int fails = 0;
    bit rnd   = 1'b0;

    logic [23:0] got[$];
    logic [23:0] exp_q[$];
`ifdef QPSK_SCRAMBLER_EN
    logic [6:0]  lf;
`endif

    typedef struct {
        logic [7:0]        data;
        logic [0:3][23:0]  hand;
    } vec_t;

    qpsk_tx_framer dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Collect accepted samples and verify output stability during stalls.
    logic        prev_stall = 1'b0;
    logic [23:0] prev_data  = 24'h0;
    always @(negedge clk) begin
        if (rst && prev_stall) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", {8'd0, out_data}, {8'd0, prev_data});
        end
        if (out_valid && out_ready) got.push_back(out_data);
        prev_stall <= rst && out_valid && !out_ready;
        prev_data  <= out_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd) out_ready = ($urandom_range(0, 9) >= 3);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!s_ready && n < 2000) begin step(); n++; end
        if (n >= 2000) check("send_timeout", 0, 1);
        step();
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin step(); n++; end
        if (n >= 5000) check("idle_timeout", 0, 1);
        rnd = 1'b0; out_ready = 1'b1;
        step();
    endtask

    function automatic logic [23:0] sym_val(input logic b1, input logic b0);
        return {b1 ? 12'hC00 : 12'h400, b0 ? 12'hC00 : 12'h400};
    endfunction

    task automatic begin_frame();
        exp_q.delete();
        got.delete();
`ifdef QPSK_SCRAMBLER_EN
        lf = 7'h7F;
`endif
        for (int s = 0; s < 32; s++)
            for (int k = 0; k < 4; k++) exp_q.push_back(s[0] ? 24'hC00C00 : 24'h400400);
    endtask

    task automatic push_byte(input logic [7:0] b, input logic [0:3][23:0] hand);
        for (int s = 0; s < 4; s++) begin
            logic [23:0] v;
`ifdef QPSK_SCRAMBLER_EN
            logic o1, o2;
            o1 = lf[6] ^ lf[3]; lf = {lf[5:0], o1};
            o2 = lf[6] ^ lf[3]; lf = {lf[5:0], o2};
            v = sym_val(b[7-2*s] ^ o1, b[6-2*s] ^ o2);
`else
            v = hand[s];
`endif
            for (int k = 0; k < 4; k++) exp_q.push_back(v);
        end
    endtask

    task automatic end_frame();
        for (int k = 0; k < 16; k++) exp_q.push_back(24'h0);
    endtask

    task automatic cmp_seq(input string nm);
        check({nm, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            if (got[i] !== exp_q[i]) check($sformatf("%s_s%0d", nm, i), {8'd0, got[i]}, {8'd0, exp_q[i]});
            else tests++;
    endtask

    vec_t vt[5];
    logic [0:3][23:0] all0, all1;

    initial begin
        vt[0] = '{data: 8'h1B, hand: {24'h400400, 24'h400C00, 24'hC00400, 24'hC00C00}};
        vt[1] = '{data: 8'h00, hand: {24'h400400, 24'h400400, 24'h400400, 24'h400400}};
        vt[2] = '{data: 8'hFF, hand: {24'hC00C00, 24'hC00C00, 24'hC00C00, 24'hC00C00}};
        vt[3] = '{data: 8'hE4, hand: {24'hC00C00, 24'hC00400, 24'h400C00, 24'h400400}};
        vt[4] = '{data: 8'h5A, hand: {24'h400C00, 24'h400C00, 24'hC00400, 24'hC00400}};
        all0 = vt[1].hand;
        all1 = vt[2].hand;

        rst = 1'b0; s_valid = 1'b0; s_data = 8'h0; s_last = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        check("rst_s_ready", {31'd0, s_ready}, 0);
        rst = 1'b1;
        step(); step();
        check("idle_out_valid", {31'd0, out_valid}, 0);
        check("idle_busy", {31'd0, busy}, 0);
        check("idle_s_ready", {31'd0, s_ready}, 1);
        check("idle_out_data", {8'd0, out_data}, 0);
        check("idle_underrun", {31'd0, underrun}, 0);

        // Single-byte frames from the vector table.
        for (int v = 0; v < 5; v++) begin
            begin_frame();
            push_byte(vt[v].data, vt[v].hand);
            end_frame();
            send_byte(vt[v].data, 1'b1);
            check($sformatf("busy_after_accept_%0d", v), {31'd0, busy}, 1);
            wait_idle();
            cmp_seq($sformatf("frame_%02h", vt[v].data));
            check($sformatf("underrun_%0d", v), {31'd0, underrun}, 0);
            check($sformatf("s_ready_end_%0d", v), {31'd0, s_ready}, 1);
        end

        // Two bytes back to back: no bubble between them.
        begin_frame();
        push_byte(8'h00, all0);
        push_byte(8'hFF, all1);
        end_frame();
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b1);
        wait_idle();
        cmp_seq("b2b");
        check("b2b_underrun", {31'd0, underrun}, 0);

        // Random back-pressure.
        begin_frame();
        push_byte(8'h1B, vt[0].hand);
        end_frame();
        rnd = 1'b1;
        send_byte(8'h1B, 1'b1);
        wait_idle();
        cmp_seq("stall");

        // Starved payload: zero symbols inserted, underrun sticky.
        begin_frame();
        push_byte(8'h00, all0);
        push_byte(8'hFF, all1);
        end_frame();
        send_byte(8'h00, 1'b0);
        repeat (164) step();
        send_byte(8'hFF, 1'b1);
        wait_idle();
        begin
            int z;
            z = got.size() - exp_q.size();
            check("urun_zeros_pos", {31'd0, z > 0}, 1);
            check("urun_zeros_mod4", z % 4, 0);
            if (z > 0 && got.size() == exp_q.size() + z) begin
                for (int i = 0; i < 144; i++)
                    if (got[i] !== exp_q[i]) check($sformatf("urun_a%0d", i), {8'd0, got[i]}, {8'd0, exp_q[i]});
                for (int i = 0; i < z; i++)
                    if (got[144+i] !== 24'h0) check($sformatf("urun_z%0d", i), {8'd0, got[144+i]}, 0);
                for (int i = 144; i < exp_q.size(); i++)
                    if (got[i+z] !== exp_q[i]) check($sformatf("urun_b%0d", i), {8'd0, got[i+z]}, {8'd0, exp_q[i]});
            end
        end
        check("urun_flag", {31'd0, underrun}, 1);
        begin_frame();
        push_byte(8'h1B, vt[0].hand);
        end_frame();
        send_byte(8'h1B, 1'b1);
        check("urun_cleared", {31'd0, underrun}, 0);
        wait_idle();
        cmp_seq("after_urun");

        // Reset mid-payload, then a clean frame.
        send_byte(8'h1B, 1'b1);
        repeat (134) step();
        rst = 1'b0;
        #1;
        check("mrst_out_valid", {31'd0, out_valid}, 0);
        check("mrst_busy", {31'd0, busy}, 0);
        check("mrst_out_data", {8'd0, out_data}, 0);
        check("mrst_underrun", {31'd0, underrun}, 0);
        check("mrst_s_ready", {31'd0, s_ready}, 0);
        step();
        rst = 1'b1;
        step(); step();
        check("mrst_idle_s_ready", {31'd0, s_ready}, 1);
        begin_frame();
        push_byte(8'h00, all0);
        end_frame();
        send_byte(8'h00, 1'b1);
        wait_idle();
        check("mrst_first", (got.size() > 0) ? {8'd0, got[0]} : 32'hFFFFFFFF, 32'h400400);
        cmp_seq("mrst_frame");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
